// File: rtl/exec_unit_if.sv
// Issue/writeback bus between the register block and exec_unit.
interface exec_unit_if;
  logic        valid_in;
  logic        ready_in;
  logic [3:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [5:0]  rd_in;
  logic        flush;
  logic        we;
  logic [5:0]  rd;
  logic [31:0] wd;
  logic        zero;

  modport master (output valid_in, op, opA, opB, rd_in, flush,
                  input  ready_in, we, rd, wd, zero);
  modport slave  (input  valid_in, op, opA, opB, rd_in, flush,
                  output ready_in, we, rd, wd, zero);
endinterface

// File: rtl/exec_unit.sv
// Single-issue integer execute unit: 1-cycle ALU ops plus an optional
// 32-cycle shift-add multiplier, enabled by defining EXEC_UNIT_MUL_EN.
module exec_unit (
  input logic        clk,
  input logic        rst_n,
  exec_unit_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4, OP_SLT = 4'd5,
                         OP_SLL = 4'd6, OP_SRL = 4'd7;

  logic [31:0] alu_res;
  logic        alu_ok;
  logic        accept;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (bus.op)
      OP_ADD:  alu_res = bus.opA + bus.opB;
      OP_SUB:  alu_res = bus.opA - bus.opB;
      OP_AND:  alu_res = bus.opA & bus.opB;
      OP_OR:   alu_res = bus.opA | bus.opB;
      OP_XOR:  alu_res = bus.opA ^ bus.opB;
      OP_SLT:  alu_res = {31'b0, $signed(bus.opA) < $signed(bus.opB)};
      OP_SLL:  alu_res = bus.opA << bus.opB[4:0];
      OP_SRL:  alu_res = bus.opA >> bus.opB[4:0];
      default: alu_ok  = 1'b0;
    endcase
  end

  // flush wins over a same-cycle issue
  assign accept = bus.valid_in & bus.ready_in & ~bus.flush;

`ifdef EXEC_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  logic [0:0]  state;
  logic [4:0]  cnt;
  logic [31:0] mul_a, mul_b, acc, mul_sum;
  logic [5:0]  mul_rd;
  logic        mul_done;

  assign bus.ready_in = (state == IDLE);
  assign mul_sum      = acc + (mul_b[0] ? mul_a : 32'd0);
  assign mul_done     = (state == MUL_BUSY) & (cnt == 5'd31) & ~bus.flush;

  // Multiplicand shifts left, multiplier shifts right; one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      acc    <= '0;
      mul_rd <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.valid_in && bus.op == OP_MUL) begin
        state  <= MUL_BUSY;
        cnt    <= '0;
        mul_a  <= bus.opA;
        mul_b  <= bus.opB;
        acc    <= '0;
        mul_rd <= bus.rd_in;
      end
    end else begin
      acc   <= mul_sum;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + 5'd1;
      if (cnt == 5'd31) state <= IDLE;
    end
  end
`else
  assign bus.ready_in = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.we   <= 1'b0;
      bus.rd   <= '0;
      bus.wd   <= '0;
      bus.zero <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      if (accept && alu_ok) begin
        bus.rd   <= bus.rd_in;
        bus.wd   <= alu_res;
        bus.zero <= (alu_res == 32'd0);
        bus.we   <= (bus.rd_in != 6'd0);
      end
`ifdef EXEC_UNIT_MUL_EN
      else if (mul_done) begin
        bus.rd   <= mul_rd;
        bus.wd   <= mul_sum;
        bus.zero <= (mul_sum == 32'd0);
        bus.we   <= (mul_rd != 6'd0);
      end
`endif
    end
  end
endmodule
